// File: rtl/logic_arb_pkg.sv
// Shared opcodes and FSM state encoding for the logic-op arbiter.
package logic_arb_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational W-wide bitwise logic unit; reserved opcodes yield 0 with err set.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one registered logic unit among NREQ requesters; 2-cycle request-to-result.
// Define LOGIC_ARB_RR_EN for round-robin arbitration, otherwise lowest index wins.
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        a_in,
  input  logic [NREQ*W-1:0]        b_in,
  input  logic [NREQ*3-1:0]        op_in,
  output logic [NREQ-1:0]          gnt,
  output logic [W-1:0]             o_result,
  output logic                     o_valid,
  output logic [$clog2(NREQ)-1:0]  o_id,
  output logic                     o_err,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_op;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   w_win;
  logic [W-1:0]    w_res;
  logic            w_err;

`ifdef LOGIC_ARB_RR_EN
  logic [IW-1:0]       r_ptr;
  logic [2*NREQ-1:0]   w_req2;
  logic [IW-1:0]       w_off;
  logic [IW:0]         w_sum;

  // Rotate req so the pointer position lands at bit 0, then map the offset back.
  always_comb begin
    w_req2 = {req, req} >> r_ptr;
    w_off  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req2[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
    w_win = w_sum[IW-1:0];
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) w_win = IW'(k);
    end
  end
`endif

  logic_unit #(.W(W)) u_logic_unit (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .result (w_res),
    .err    (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_win    <= '0;
      gnt      <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
      o_id     <= '0;
      o_err    <= 1'b0;
      busy     <= 1'b0;
`ifdef LOGIC_ARB_RR_EN
      r_ptr    <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (|req) begin
            r_a     <= a_in[w_win*W +: W];
            r_b     <= b_in[w_win*W +: W];
            r_op    <= op_in[w_win*3 +: 3];
            r_win   <= w_win;
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            busy    <= 1'b1;
            r_state <= EXEC;
`ifdef LOGIC_ARB_RR_EN
            r_ptr   <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`endif
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        EXEC: begin
          gnt      <= '0;
          o_result <= w_res;
          o_err    <= w_err;
          o_id     <= r_win;
          o_valid  <= 1'b1;
          r_state  <= DONE;
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter (NREQ=4, W=8).
module tb_logic_op_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ*3-1:0] op_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      o_result;
  logic              o_valid;
  logic [1:0]        o_id;
  logic              o_err;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic_op_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .op_in    (op_in),
    .gnt      (gnt),
    .o_result (o_result),
    .o_valid  (o_valid),
    .o_id     (o_id),
    .o_err    (o_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic load(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
    op_in[idx*3 +: 3] = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; op_in = '0;
    @(negedge clk);
    total++;
    if ({gnt, o_result, o_valid, o_id, o_err, busy} !== '0) begin
      bad++; $display("FAIL reset_init: got %h required 0", {gnt, o_result, o_valid, o_id, o_err, busy});
    end
    rst_n = 1'b1;
    load(1, 8'hF0, 8'h3C, 3'b100);
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_pre_exec: gnt=%b busy=%b required 0010/1", gnt, busy);
    end
    rst_n = 1'b0;
    req = '0;
    #1;
    total++;
    if ({gnt, o_result, o_valid, o_id, o_err, busy} !== '0) begin
      bad++; $display("FAIL reset_async: got %h required 0", {gnt, o_result, o_valid, o_id, o_err, busy});
    end
    @(negedge clk);
    total++;
    if ({gnt, o_result, o_valid, o_id, o_err, busy} !== '0) begin
      bad++; $display("FAIL reset_mid_exec: got %h required 0", {gnt, o_result, o_valid, o_id, o_err, busy});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
        bad++; $display("FAIL reset_idle cycle %0d: valid=%b busy=%b gnt=%b required 0/0/0", c, o_valid, busy, gnt);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    load(1, 8'hF0, 8'h3C, 3'b100);
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010 || o_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_gnt: gnt=%b valid=%b busy=%b required 0010/0/1", gnt, o_valid, busy);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 8'hCC || o_id !== 2'd1 || o_err !== 1'b0 || gnt !== '0) begin
      bad++; $display("FAIL single_result: valid=%b res=%h id=%0d err=%b gnt=%b required 1/cc/1/0/0000",
                      o_valid, o_result, o_id, o_err, gnt);
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_after: valid=%b busy=%b required 0/0", o_valid, busy);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_res [8] = '{8'h0A, 8'hAF, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'h00, 8'h00};
    logic       exp_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load(0, 8'hAA, 8'h0F, 3'(i));
      req = 4'b0001;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_result !== exp_res[i] || o_err !== exp_err[i] || o_id !== 2'd0) begin
        bad++; $display("FAIL opcode %0d: valid=%b res=%h err=%b id=%0d required 1/%h/%b/0",
                        i, o_valid, o_result, o_err, o_id, exp_res[i], exp_err[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
`ifdef LOGIC_ARB_RR_EN
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    logic [1:0] exp_id [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 8'h12, 8'h34, 3'b001);
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      eg = 4'b0001 << exp_id[c/2];
      total++;
      if (c % 2 == 0) begin
        if (gnt !== eg || o_valid !== 1'b0) begin
          bad++; $display("FAIL rr_gnt step %0d: gnt=%b valid=%b required %b/0", c, gnt, o_valid, eg);
        end
      end else begin
        if (o_valid !== 1'b1 || o_id !== exp_id[c/2] || o_result !== 8'h36 || gnt !== '0) begin
          bad++; $display("FAIL rr_id step %0d: valid=%b id=%0d res=%h gnt=%b required 1/%0d/36/0000",
                          c, o_valid, o_id, o_result, gnt, exp_id[c/2]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_late_join();
`ifdef LOGIC_ARB_RR_EN
    logic [3:0] exp_g  [3] = '{4'b1000, 4'b0001, 4'b1000};
    logic [1:0] exp_id [2] = '{2'd3, 2'd0};
`else
    logic [3:0] exp_g  [3] = '{4'b0001, 4'b0001, 4'b0001};
    logic [1:0] exp_id [2] = '{2'd0, 2'd0};
`endif
    do_reset();
    load(0, 8'hFF, 8'h0F, 3'b000);
    load(3, 8'hFF, 8'hF0, 3'b000);
    req = 4'b0001;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL late_first_gnt: gnt=%b required 0001", gnt);
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_id !== 2'd0) begin
      bad++; $display("FAIL late_first_id: valid=%b id=%0d required 1/0", o_valid, o_id);
    end
    req = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (c % 2 == 0) begin
        if (gnt !== exp_g[c/2]) begin
          bad++; $display("FAIL late_gnt step %0d: gnt=%b required %b", c, gnt, exp_g[c/2]);
        end
      end else begin
        if (o_valid !== 1'b1 || o_id !== exp_id[c/2]) begin
          bad++; $display("FAIL late_id step %0d: valid=%b id=%0d required 1/%0d", c, o_valid, o_id, exp_id[c/2]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_operand_change();
    do_reset();
    load(2, 8'h33, 8'h55, 3'b000);
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin
      bad++; $display("FAIL opchg_gnt: gnt=%b required 0100", gnt);
    end
    load(2, 8'hFF, 8'h00, 3'b101);
    req = '0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 8'h11 || o_id !== 2'd2 || o_err !== 1'b0) begin
      bad++; $display("FAIL opchg_result: valid=%b res=%h id=%0d err=%b required 1/11/2/0",
                      o_valid, o_result, o_id, o_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load(1, 8'h0F, 8'hF0, 3'b001);
    load(2, 8'hFF, 8'h0F, 3'b100);
    req = 4'b0110;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL b2b_gnt1: gnt=%b required 0010", gnt);
    end
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_id !== 2'd1 || o_result !== 8'hFF || gnt !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_res1: valid=%b id=%0d res=%h gnt=%b busy=%b required 1/1/ff/0000/1",
                      o_valid, o_id, o_result, gnt, busy);
    end
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_gnt2: gnt=%b valid=%b required 0100/0", gnt, o_valid);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_id !== 2'd2 || o_result !== 8'hF0) begin
      bad++; $display("FAIL b2b_res2: valid=%b id=%0d res=%h required 1/2/f0", o_valid, o_id, o_result);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: busy=%b valid=%b required 0/0", busy, o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ops();
    test_round_robin();
    test_late_join();
    test_operand_change();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
